// File: rtl/note_voice_mixer.sv
// Four-voice square-wave mixer driven by APU note codes.
// Each voice has a phase accumulator and a linear-decay envelope; the mix is emitted once per sample tick.
module note_voice_mixer #(
  parameter int          CLK_DIV     = 4,
  parameter logic [15:0] BASE_INC    = 16'd256,
  parameter int          DECAY_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_clk,
  input  logic [3:0] t0_me,
  input  logic [3:0] t1_me,
  input  logic [3:0] t2_me,
  input  logic [3:0] t3_me,
  input  logic       mute,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic [3:0] voice_active
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_TICKS - 1);

  logic          note_clk_q;
  logic [CW-1:0] div_q, div_d;
  logic          tick, latch;
  logic          tick_q;
  logic          valid_q;
  logic [7:0]    sample_q, sample_d;
  logic signed [7:0] mix;

  logic [3:0]    note_in [4];
  logic [3:0]    n_q [4];
  logic [3:0]    n_d [4];
  logic [15:0]   p_q [4];
  logic [15:0]   p_d [4];
  logic [3:0]    e_q [4];
  logic [3:0]    e_d [4];
  logic [DW-1:0] d_q [4];
  logic [DW-1:0] d_d [4];

  assign note_in[0] = t0_me;
  assign note_in[1] = t1_me;
  assign note_in[2] = t2_me;
  assign note_in[3] = t3_me;

  assign latch = note_clk & ~note_clk_q;
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + CW'(1);

  // Rest and onset take priority over the tick; a repeated code falls through and ticks normally.
  always_comb begin
    for (int v = 0; v < 4; v++) begin
      n_d[v] = n_q[v];
      p_d[v] = p_q[v];
      e_d[v] = e_q[v];
      d_d[v] = d_q[v];
      if (latch && (note_in[v] == 4'd0)) begin
        n_d[v] = 4'd0;
        p_d[v] = 16'd0;
        e_d[v] = 4'd0;
      end else if (latch && (note_in[v] != n_q[v])) begin
        n_d[v] = note_in[v];
        p_d[v] = 16'd0;
        e_d[v] = 4'd15;
        d_d[v] = '0;
      end else if (tick && (n_q[v] != 4'd0)) begin
        p_d[v] = p_q[v] + 16'({12'd0, n_q[v]} * BASE_INC);
        if (e_q[v] != 4'd0) begin
          if (d_q[v] == DEC_LAST) begin
            d_d[v] = '0;
            e_d[v] = e_q[v] - 4'd1;
          end else begin
            d_d[v] = d_q[v] + DW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    mix = 8'sd0;
    for (int v = 0; v < 4; v++) begin
      if (n_q[v] != 4'd0) begin
        if (p_q[v][15]) mix = mix + $signed({4'd0, e_q[v]});
        else            mix = mix - $signed({4'd0, e_q[v]});
      end
    end
    sample_d = mute ? 8'd0 : mix;
  end

  always_comb begin
    voice_active = 4'd0;
    for (int v = 0; v < 4; v++) begin
      voice_active[v] = (n_q[v] != 4'd0) && (e_q[v] != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_clk_q <= 1'b0;
      div_q      <= '0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      sample_q   <= 8'd0;
      for (int v = 0; v < 4; v++) begin
        n_q[v] <= 4'd0;
        p_q[v] <= 16'd0;
        e_q[v] <= 4'd0;
        d_q[v] <= '0;
      end
    end else begin
      note_clk_q <= note_clk;
      div_q      <= div_d;
      tick_q     <= tick;
      valid_q    <= tick_q;
      if (tick_q) sample_q <= sample_d;
      for (int v = 0; v < 4; v++) begin
        n_q[v] <= n_d[v];
        p_q[v] <= p_d[v];
        e_q[v] <= e_d[v];
        d_q[v] <= d_d[v];
      end
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_note_voice_mixer.sv
// Scoreboard bench for note_voice_mixer: two instances (decay 8 and decay 1000) share one stimulus.
// Expected samples come from closed-form per-voice formulas tracked per note onset.
module tb_note_voice_mixer;

  logic       clk;
  logic       rst_n;
  logic       note_clk;
  logic [3:0] t_me [4];
  logic       mute;

  logic [7:0] so_a, so_b;
  logic       sv_a, sv_b;
  logic [3:0] va_a, va_b;

  typedef struct {
    int       sa;
    int       sb;
    logic [3:0] vaa;
    logic [3:0] vab;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int nt [4];
  int kk [4];
  bit muted;

  note_voice_mixer #(.CLK_DIV(4), .BASE_INC(16'd256), .DECAY_TICKS(8)) u_a (
    .clk(clk), .reset(rst_n), .note_clk(note_clk),
    .t0_me(t_me[0]), .t1_me(t_me[1]), .t2_me(t_me[2]), .t3_me(t_me[3]),
    .mute(mute), .sample_out(so_a), .sample_valid(sv_a), .voice_active(va_a)
  );

  note_voice_mixer #(.CLK_DIV(4), .BASE_INC(16'd256), .DECAY_TICKS(1000)) u_b (
    .clk(clk), .reset(rst_n), .note_clk(note_clk),
    .t0_me(t_me[0]), .t1_me(t_me[1]), .t2_me(t_me[2]), .t3_me(t_me[3]),
    .mute(mute), .sample_out(so_b), .sample_valid(sv_b), .voice_active(va_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Contribution of one voice with note n, k ticks after onset, envelope step every d ticks.
  function automatic int vc(input int n, input int k, input int d);
    int e;
    int p;
    if (n == 0) return 0;
    e = 15 - k / d;
    if (e < 0) e = 0;
    p = (k * n * 256) % 65536;
    return (p >= 32768) ? e : -e;
  endfunction

  always @(negedge clk) begin
    if (sv_a || sv_b) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_b", int'(sv_b), 1);
        chk("valid_a", int'(sv_a), 1);
        chk("sample_a", int'($signed(so_a)), e.sa);
        chk("sample_b", int'($signed(so_b)), e.sb);
        chk("active_a", int'(va_a), int'(e.vaa));
        chk("active_b", int'(va_b), int'(e.vab));
      end
    end
  end

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sv_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got none expected a pulse within 20 cycles");
      q.delete();
    end
    #1;
  endtask

  task automatic one_sample();
    exp_t e;
    e.sa = 0; e.sb = 0; e.vaa = 4'd0; e.vab = 4'd0;
    for (int v = 0; v < 4; v++) begin
      if (nt[v] != 0) begin
        kk[v]++;
        e.sa += vc(nt[v], kk[v], 8);
        e.sb += vc(nt[v], kk[v], 1000);
        e.vaa[v] = (kk[v] < 120);
        e.vab[v] = (kk[v] < 15000);
      end
    end
    if (muted) begin
      e.sa = 0;
      e.sb = 0;
    end
    q.push_back(e);
    wait_valid();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_sample();
  endtask

  // Called just after a sample pulse, so the latch lands between two ticks.
  task automatic latch(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int v = 0; v < 4; v++) begin
      t_me[v] = 4'(c[v]);
      if (c[v] == 0) begin
        nt[v] = 0;
        kk[v] = 0;
      end else if (c[v] != nt[v]) begin
        nt[v] = c[v];
        kk[v] = 0;
      end
    end
    note_clk = 1'b1;
    @(negedge clk);
    #1;
    note_clk = 1'b0;
  endtask

  task automatic clear_model();
    for (int v = 0; v < 4; v++) begin
      nt[v] = 0;
      kk[v] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sample_a"}, int'(so_a), 0);
    chk({tag, "_sample_b"}, int'(so_b), 0);
    chk({tag, "_valid_a"},  int'(sv_a), 0);
    chk({tag, "_valid_b"},  int'(sv_b), 0);
    chk({tag, "_active_a"}, int'(va_a), 0);
    chk({tag, "_active_b"}, int'(va_b), 0);
  endtask

  initial begin
    rst_n    = 1'b1;
    note_clk = 1'b0;
    mute     = 1'b0;
    muted    = 1'b0;
    for (int v = 0; v < 4; v++) t_me[v] = 4'd0;
    clear_model();

    #2 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(3);

    latch(1, 0, 0, 0);
    run(260);

    latch(0, 0, 0, 0);
    run(2);
    latch(1, 1, 1, 1);
    run(3);
    latch(0, 0, 0, 0);
    run(1);
    latch(1, 1, 0, 0);
    run(2);
    latch(0, 0, 0, 0);
    run(1);

    latch(3, 0, 0, 0);
    run(20);
    latch(3, 0, 0, 0);
    run(5);
    latch(5, 0, 0, 0);
    run(3);
    latch(0, 0, 0, 0);
    run(2);

    latch(2, 0, 7, 15);
    run(6);

    latch(0, 2, 0, 0);
    run(5);
    mute  = 1'b1;
    muted = 1'b1;
    run(5);
    mute  = 1'b0;
    muted = 1'b0;
    run(3);

    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    clear_model();
    for (int v = 0; v < 4; v++) t_me[v] = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run(4);
    latch(1, 0, 0, 0);
    run(3);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
